sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Top-level command arbiter for the SDRAM controller.
- Consumes init, auto-refresh, write and read sub-block outputs (cmd/addr/bank/req/end) and grants one requester at a time via a one-cycle enable pulse.
- Muxes the granted requester's command and address onto the SDRAM pins and drives the bidirectional DQ bus.
- Sits directly downstream of the auto-refresh generator: it consumes aref_req, aref_end, aref_cmd and aref_addr, and produces aref_en.

Parameters:
- DQ_W, 16, SDRAM data bus width.
- TIMEOUT_CYC, 1023, maximum cycles allowed in AREF/WRITE/READ before forced return to ARBIT; range 1..1023.

Ports:
- sclk  in  1  system clock (all logic on rising edge).
- rst_n  in  1  asynchronous, active-low reset.
- init_cmd  in  4  init sequencer command {cs_n,ras_n,cas_n,we_n}.
- init_addr  in  12  init sequencer address.
- init_done  in  1  level; initialization complete.
- aref_req  in  1  refresh request (level until granted).
- aref_end  in  1  one-cycle refresh-complete pulse.
- aref_cmd  in  4  refresh command.
- aref_addr  in  12  refresh address.
- aref_en  out  1  refresh grant pulse.
- wr_req  in  1  write request.
- wr_end  in  1  write burst complete pulse.
- wr_cmd  in  4  write command.
- wr_addr  in  12  write address.
- wr_bank  in  2  write bank.
- wr_data  in  DQ_W  write data.
- wr_dq_oe  in  1  write data output enable.
- wr_en  out  1  write grant pulse.
- rd_req  in  1  read request.
- rd_end  in  1  read burst complete pulse.
- rd_cmd  in  4  read command.
- rd_addr  in  12  read address.
- rd_bank  in  2  read bank.
- rd_en  out  1  read grant pulse.
- rd_data  out  DQ_W  data sampled from the bus.
- arb_err  out  1  one-cycle timeout pulse.
- sdram_cke  out  1  clock enable.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
- sdram_bank  out  2  bank address.
- sdram_addr  out  12  address.
- sdram_dq  inout  DQ_W  data bus.

Behaviour:
- FSM states, 3-bit register: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.

FSM transitions:
- INIT -> ARBIT when init_done=1.
- ARBIT: fixed priority aref_req > wr_req > rd_req. The highest asserted request moves the FSM to AREF, WRITE or READ on the next edge. With no request, the FSM stays in ARBIT.
- AREF -> ARBIT on aref_end=1. WRITE -> ARBIT on wr_end=1. READ -> ARBIT on rd_end=1.
- An end pulse arriving while the FSM is not in the matching state is ignored.
- Minimum one ARBIT cycle between any two grants.

Grant pulses:
- aref_en, wr_en and rd_en are registered.
- Each is 1 for exactly one cycle: the first cycle the FSM is in the corresponding state.
- At most one of them is high in any cycle.
- Reset value of all three is 0.

Timeout:
- A 10-bit busy counter clears on entry to AREF/WRITE/READ and increments every cycle in those states.
- If the counter reaches TIMEOUT_CYC before the matching end pulse, the FSM returns to ARBIT and arb_err pulses 1 for one cycle.
- If the end pulse and timeout occur in the same cycle, end wins and arb_err stays 0.
- The counter holds 0 in INIT and ARBIT. arb_err resets to 0.

Command mux (combinational from state):
- INIT: init_cmd / init_addr.
- AREF: aref_cmd / aref_addr.
- WRITE: wr_cmd / wr_addr / wr_bank.
- READ: rd_cmd / rd_addr / rd_bank.
- ARBIT: NOP 4'b0111, addr 12'd0.
- sdram_bank is 2'b00 outside WRITE/READ.
- {cs_n,ras_n,cas_n,we_n} = the selected cmd.
- During reset, the outputs show INIT-state mux values.

Other outputs:
- sdram_cke is constant 1.
- sdram_dq = wr_data when (state==WRITE && wr_dq_oe==1), else high-Z.
- rd_data = sdram_dq (combinational). The read block handles CAS-latency capture.

Reset:
- Asynchronous reset mid-operation returns the FSM to INIT, zeroes the counter, clears all pulses and releases DQ to high-Z immediately.

Test Plan:
1. Reset with init_done=0, init_cmd=4'b0010, init_addr=12'h400 -> sdram pins show 0010/12'h400; all en=0; DQ is Z. Raise init_done -> next cycle the FSM is in ARBIT and the pins show 0111/0.
2. In ARBIT, assert aref_req, wr_req and rd_req in the same cycle -> aref_en=1 for one cycle only, wr_en=rd_en=0, pins follow aref_cmd. After aref_end, one ARBIT cycle, then wr_en pulses. After wr_end, one ARBIT cycle, then rd_en pulses.
3. In WRITE with wr_dq_oe=1 and wr_data=16'hA5C3 -> sdram_dq=16'hA5C3. Drop wr_dq_oe -> Z. In READ, drive bus 16'h1234 -> rd_data=16'h1234.
4. Grant a refresh and withhold aref_end with TIMEOUT_CYC=8 -> after 8 cycles in AREF, arb_err=1 for one cycle and the FSM is back in ARBIT. A later stray aref_end in ARBIT causes no state change.
5. Grant a read and assert rst_n=0 two cycles later -> the FSM is in INIT asynchronously, rd_en=0, arb_err=0, and the pins show init_cmd.
6. Hold rd_req=1 continuously while aref_req rises mid-read -> the read completes on rd_end, then aref_en is granted before the next rd_en.

Source files
------------

// File: rtl/sdram_arbit_if.sv
// Requester-side bundle for the SDRAM command arbiter: init, refresh, write and read handshakes.
// Requesters drive the request/end/command fields; the arbiter returns the grant pulses.
interface sdram_arbit_if #(
  parameter int unsigned DQ_W = 16
);
  logic [3:0]      init_cmd;
  logic [11:0]     init_addr;
  logic            init_done;

  logic            aref_req;
  logic            aref_end;
  logic [3:0]      aref_cmd;
  logic [11:0]     aref_addr;
  logic            aref_en;

  logic            wr_req;
  logic            wr_end;
  logic [3:0]      wr_cmd;
  logic [11:0]     wr_addr;
  logic [1:0]      wr_bank;
  logic [DQ_W-1:0] wr_data;
  logic            wr_dq_oe;
  logic            wr_en;

  logic            rd_req;
  logic            rd_end;
  logic [3:0]      rd_cmd;
  logic [11:0]     rd_addr;
  logic [1:0]      rd_bank;
  logic            rd_en;

  modport master (
    output init_cmd, init_addr, init_done,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, wr_en, rd_en
  );

  modport slave (
    input  init_cmd, init_addr, init_done,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, wr_en, rd_en
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: fixed-priority grant (refresh > write > read) with a busy-state
// timeout, command/address mux onto the SDRAM pins and the bidirectional DQ driver.
module sdram_arbit #(
  parameter int unsigned DQ_W        = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic             sclk,
  input  logic             rst_n,
  sdram_arbit_if.slave     req_if,
  output logic [DQ_W-1:0]  rd_data_o,
  output logic             arb_err_o,
  output logic             sdram_cke_o,
  output logic             sdram_cs_n_o,
  output logic             sdram_ras_n_o,
  output logic             sdram_cas_n_o,
  output logic             sdram_we_n_o,
  output logic [1:0]       sdram_bank_o,
  output logic [11:0]      sdram_addr_o,
  inout  wire  [DQ_W-1:0]  sdram_dq_io
);

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StArbit = 3'd1,
    StAref  = 3'd2,
    StWrite = 3'd3,
    StRead  = 3'd4
  } state_e;

  localparam logic [3:0]  CmdNop   = 4'b0111;
  localparam logic [10:0] TimeoutW = 11'(TIMEOUT_CYC);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       aref_en_q, aref_en_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       err_q, err_d;
  logic       timeout;
  logic [3:0] cmd;

  // Timeout fires on the TIMEOUT_CYC-th cycle spent in a busy state.
  assign timeout = ({1'b0, cnt_q} + 11'd1) == TimeoutW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    aref_en_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      StInit: begin
        if (req_if.init_done) state_d = StArbit;
      end
      StArbit: begin
        if (req_if.aref_req) begin
          state_d   = StAref;
          aref_en_d = 1'b1;
        end else if (req_if.wr_req) begin
          state_d = StWrite;
          wr_en_d = 1'b1;
        end else if (req_if.rd_req) begin
          state_d = StRead;
          rd_en_d = 1'b1;
        end
      end
      StAref: begin
        if (req_if.aref_end) begin
          state_d = StArbit;
        end else if (timeout) begin
          state_d = StArbit;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StWrite: begin
        if (req_if.wr_end) begin
          state_d = StArbit;
        end else if (timeout) begin
          state_d = StArbit;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StRead: begin
        if (req_if.rd_end) begin
          state_d = StArbit;
        end else if (timeout) begin
          state_d = StArbit;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    cmd          = req_if.init_cmd;
    sdram_addr_o = req_if.init_addr;
    sdram_bank_o = 2'b00;
    case (state_q)
      StInit: begin
        cmd          = req_if.init_cmd;
        sdram_addr_o = req_if.init_addr;
      end
      StArbit: begin
        cmd          = CmdNop;
        sdram_addr_o = 12'd0;
      end
      StAref: begin
        cmd          = req_if.aref_cmd;
        sdram_addr_o = req_if.aref_addr;
      end
      StWrite: begin
        cmd          = req_if.wr_cmd;
        sdram_addr_o = req_if.wr_addr;
        sdram_bank_o = req_if.wr_bank;
      end
      StRead: begin
        cmd          = req_if.rd_cmd;
        sdram_addr_o = req_if.rd_addr;
        sdram_bank_o = req_if.rd_bank;
      end
      default: begin
        cmd          = req_if.init_cmd;
        sdram_addr_o = req_if.init_addr;
      end
    endcase
  end

  assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = cmd;
  assign sdram_cke_o = 1'b1;

  assign req_if.aref_en = aref_en_q;
  assign req_if.wr_en   = wr_en_q;
  assign req_if.rd_en   = rd_en_q;
  assign arb_err_o      = err_q;

  // Reset forces StInit, so the bus is released immediately on rst_n assertion.
  assign sdram_dq_io = (state_q == StWrite && req_if.wr_dq_oe) ? req_if.wr_data : 'z;
  assign rd_data_o   = sdram_dq_io;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed scenarios plus a randomized run against a
// grant/owner model built from the arbitration rules.
module tb_sdram_arbit;
  localparam int unsigned DqW = 16;
  localparam int unsigned To  = 8;

  logic           sclk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DqW-1:0] rd_data;
  logic           arb_err;
  logic           cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]     bank;
  logic [11:0]    addr;
  wire  [DqW-1:0] dq;
  logic [DqW-1:0] tb_dq = '0;
  logic           tb_dq_en = 1'b0;
  logic [3:0]     cmd;

  int n_checks = 0;
  int n_errors = 0;

  // model of the arbiter: owner 0=nobody, 1=refresh, 2=write, 3=read
  bit m_inited;
  int m_owner;
  int m_age;
  bit m_grant;
  bit m_err;

  sdram_arbit_if #(.DQ_W(DqW)) bus_if ();

  sdram_arbit #(.DQ_W(DqW), .TIMEOUT_CYC(To)) dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .req_if        (bus_if.slave),
    .rd_data_o     (rd_data),
    .arb_err_o     (arb_err),
    .sdram_cke_o   (cke),
    .sdram_cs_n_o  (cs_n),
    .sdram_ras_n_o (ras_n),
    .sdram_cas_n_o (cas_n),
    .sdram_we_n_o  (we_n),
    .sdram_bank_o  (bank),
    .sdram_addr_o  (addr),
    .sdram_dq_io   (dq)
  );

  assign dq  = tb_dq_en ? tb_dq : 'z;
  assign cmd = {cs_n, ras_n, cas_n, we_n};

  always #5 sclk = ~sclk;

  task automatic idle_inputs();
    bus_if.aref_req = 0; bus_if.aref_end = 0;
    bus_if.wr_req = 0;   bus_if.wr_end = 0;   bus_if.wr_dq_oe = 0;
    bus_if.rd_req = 0;   bus_if.rd_end = 0;
    tb_dq_en = 0;
  endtask

  task automatic fixed_fields();
    bus_if.init_cmd = 4'b0010; bus_if.init_addr = 12'h400;
    bus_if.aref_cmd = 4'b0001; bus_if.aref_addr = 12'h0AA;
    bus_if.wr_cmd = 4'b0100;   bus_if.wr_addr = 12'h123; bus_if.wr_bank = 2'b10;
    bus_if.wr_data = 16'hA5C3;
    bus_if.rd_cmd = 4'b0101;   bus_if.rd_addr = 12'h456; bus_if.rd_bank = 2'b01;
  endtask

  task automatic test_reset();
    fixed_fields();
    idle_inputs();
    bus_if.init_done = 0;
    rst_n = 0;
    tb_dq_en = 1; tb_dq = 16'h5A3C;
    @(negedge sclk); #1;
    n_checks++; if (cmd !== 4'b0010) begin n_errors++; $display("FAIL reset_cmd got=%b exp=0010", cmd); end
    n_checks++; if (addr !== 12'h400) begin n_errors++; $display("FAIL reset_addr got=%h exp=400", addr); end
    n_checks++; if (bank !== 2'b00) begin n_errors++; $display("FAIL reset_bank got=%b exp=00", bank); end
    n_checks++;
    if ({bus_if.aref_en, bus_if.wr_en, bus_if.rd_en, arb_err} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_pulses got=%b exp=0000",
               {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en, arb_err});
    end
    n_checks++; if (cke !== 1'b1) begin n_errors++; $display("FAIL reset_cke got=%b exp=1", cke); end
    n_checks++;
    if (rd_data !== 16'h5A3C) begin n_errors++; $display("FAIL reset_dq_z got=%h exp=5a3c", rd_data); end
    tb_dq_en = 0;
    rst_n = 1;
    @(negedge sclk);
    n_checks++; if (cmd !== 4'b0010) begin n_errors++; $display("FAIL init_hold got=%b exp=0010", cmd); end
    bus_if.init_done = 1;
    @(negedge sclk);
    n_checks++; if (cmd !== 4'b0111) begin n_errors++; $display("FAIL arbit_nop got=%b exp=0111", cmd); end
    n_checks++; if (addr !== 12'd0) begin n_errors++; $display("FAIL arbit_addr got=%h exp=000", addr); end
  endtask

  task automatic test_priority();
    bus_if.aref_req = 1; bus_if.wr_req = 1; bus_if.rd_req = 1;
    @(negedge sclk);
    n_checks++;
    if ({bus_if.aref_en, bus_if.wr_en, bus_if.rd_en} !== 3'b100) begin
      n_errors++;
      $display("FAIL prio_aref_en got=%b exp=100", {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en});
    end
    n_checks++; if (cmd !== 4'b0001) begin n_errors++; $display("FAIL prio_aref_cmd got=%b exp=0001", cmd); end
    n_checks++; if (addr !== 12'h0AA) begin n_errors++; $display("FAIL prio_aref_addr got=%h exp=0aa", addr); end
    bus_if.aref_req = 0;
    @(negedge sclk);
    n_checks++; if (bus_if.aref_en !== 1'b0) begin n_errors++; $display("FAIL aref_en_width got=1 exp=0"); end
    bus_if.aref_end = 1;
    @(negedge sclk);
    bus_if.aref_end = 0;
    n_checks++;
    if (cmd !== 4'b0111 || bus_if.wr_en !== 1'b0) begin
      n_errors++; $display("FAIL gap_after_aref got=%b/%b exp=0111/0", cmd, bus_if.wr_en);
    end
    @(negedge sclk);
    n_checks++;
    if ({bus_if.aref_en, bus_if.wr_en, bus_if.rd_en} !== 3'b010) begin
      n_errors++;
      $display("FAIL prio_wr_en got=%b exp=010", {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en});
    end
    n_checks++;
    if ({cmd, addr, bank} !== {4'b0100, 12'h123, 2'b10}) begin
      n_errors++; $display("FAIL prio_wr_pins got=%b/%h/%b exp=0100/123/10", cmd, addr, bank);
    end
    bus_if.wr_req = 0; bus_if.wr_end = 1;
    @(negedge sclk);
    bus_if.wr_end = 0;
    n_checks++;
    if (cmd !== 4'b0111 || bus_if.rd_en !== 1'b0) begin
      n_errors++; $display("FAIL gap_after_wr got=%b/%b exp=0111/0", cmd, bus_if.rd_en);
    end
    @(negedge sclk);
    n_checks++;
    if ({bus_if.aref_en, bus_if.wr_en, bus_if.rd_en} !== 3'b001) begin
      n_errors++;
      $display("FAIL prio_rd_en got=%b exp=001", {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en});
    end
    n_checks++;
    if ({cmd, addr, bank} !== {4'b0101, 12'h456, 2'b01}) begin
      n_errors++; $display("FAIL prio_rd_pins got=%b/%h/%b exp=0101/456/01", cmd, addr, bank);
    end
  endtask

  // Entered while the read granted by test_priority is still in progress.
  task automatic test_dq();
    tb_dq_en = 1; tb_dq = 16'h1234;
    #1;
    n_checks++; if (rd_data !== 16'h1234) begin n_errors++; $display("FAIL rd_data got=%h exp=1234", rd_data); end
    tb_dq_en = 0;
    bus_if.rd_req = 0; bus_if.rd_end = 1;
    @(negedge sclk);
    bus_if.rd_end = 0;
    bus_if.wr_req = 1; bus_if.wr_dq_oe = 1; bus_if.wr_data = 16'hA5C3;
    @(negedge sclk); #1;
    n_checks++; if (dq !== 16'hA5C3) begin n_errors++; $display("FAIL wr_dq_drive got=%h exp=a5c3", dq); end
    bus_if.wr_req = 0; bus_if.wr_dq_oe = 0;
    tb_dq_en = 1; tb_dq = 16'h5A3C;
    #1;
    n_checks++; if (rd_data !== 16'h5A3C) begin n_errors++; $display("FAIL wr_dq_release got=%h exp=5a3c", rd_data); end
    tb_dq_en = 0;
    bus_if.wr_end = 1;
    @(negedge sclk);
    bus_if.wr_end = 0;
  endtask

  task automatic test_timeout();
    bus_if.aref_req = 1;
    @(negedge sclk);
    bus_if.aref_req = 0;
    for (int i = 0; i < To; i++) begin
      n_checks++;
      if (arb_err !== 1'b0 || cmd !== 4'b0001) begin
        n_errors++; $display("FAIL to_busy[%0d] got=%b/%b exp=0/0001", i, arb_err, cmd);
      end
      @(negedge sclk);
    end
    n_checks++;
    if (arb_err !== 1'b1 || cmd !== 4'b0111) begin
      n_errors++; $display("FAIL to_err got=%b/%b exp=1/0111", arb_err, cmd);
    end
    @(negedge sclk);
    n_checks++; if (arb_err !== 1'b0) begin n_errors++; $display("FAIL to_err_width got=1 exp=0"); end
    bus_if.aref_end = 1;
    @(negedge sclk);
    bus_if.aref_end = 0;
    @(negedge sclk);
    n_checks++;
    if (cmd !== 4'b0111 || {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en} !== 3'b000) begin
      n_errors++; $display("FAIL stray_end got=%b/%b exp=0111/000", cmd,
                           {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en});
    end
  endtask

  task automatic test_reset_mid();
    bus_if.rd_req = 1;
    @(negedge sclk);
    n_checks++; if (bus_if.rd_en !== 1'b1) begin n_errors++; $display("FAIL rm_grant got=0 exp=1"); end
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus_if.rd_en, arb_err} !== 2'b00 || cmd !== 4'b0010 || addr !== 12'h400) begin
      n_errors++; $display("FAIL rm_async got=%b%b/%b/%h exp=00/0010/400", bus_if.rd_en, arb_err,
                           cmd, addr);
    end
    bus_if.rd_req = 0;
    @(negedge sclk);
    rst_n = 1;
    @(negedge sclk);
    n_checks++; if (cmd !== 4'b0111) begin n_errors++; $display("FAIL rm_recover got=%b exp=0111", cmd); end
  endtask

  task automatic test_back_to_back();
    bus_if.rd_req = 1;
    @(negedge sclk);
    n_checks++; if (bus_if.rd_en !== 1'b1) begin n_errors++; $display("FAIL b2b_rd1 got=0 exp=1"); end
    bus_if.aref_req = 1;
    @(negedge sclk);
    @(negedge sclk);
    bus_if.rd_end = 1;
    @(negedge sclk);
    bus_if.rd_end = 0;
    n_checks++; if (cmd !== 4'b0111) begin n_errors++; $display("FAIL b2b_gap got=%b exp=0111", cmd); end
    @(negedge sclk);
    n_checks++;
    if ({bus_if.aref_en, bus_if.rd_en} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_aref_first got=%b exp=10", {bus_if.aref_en, bus_if.rd_en});
    end
    bus_if.aref_req = 0; bus_if.aref_end = 1;
    @(negedge sclk);
    bus_if.aref_end = 0;
    @(negedge sclk);
    n_checks++; if (bus_if.rd_en !== 1'b1) begin n_errors++; $display("FAIL b2b_rd2 got=0 exp=1"); end
    bus_if.rd_req = 0; bus_if.rd_end = 1;
    @(negedge sclk);
    bus_if.rd_end = 0;
  endtask

  task automatic model_step();
    bit ended;
    if (!m_inited) begin
      m_grant = 0; m_err = 0;
      if (bus_if.init_done) begin m_inited = 1; m_owner = 0; end
    end else if (m_owner == 0) begin
      m_err = 0; m_grant = 0;
      if (bus_if.aref_req) m_owner = 1;
      else if (bus_if.wr_req) m_owner = 2;
      else if (bus_if.rd_req) m_owner = 3;
      if (m_owner != 0) begin m_grant = 1; m_age = 0; end
    end else begin
      m_grant = 0; m_err = 0;
      ended = (m_owner == 1) ? bus_if.aref_end : (m_owner == 2) ? bus_if.wr_end : bus_if.rd_end;
      if (ended) m_owner = 0;
      else if (m_age + 1 == int'(To)) begin m_owner = 0; m_err = 1; end
      else m_age++;
    end
  endtask

  task automatic test_random();
    logic [3:0]  e_cmd;
    logic [11:0] e_addr;
    logic [1:0]  e_bank;
    logic [2:0]  e_en;
    @(negedge sclk);
    idle_inputs();
    bus_if.init_done = 0;
    rst_n = 0; #1; rst_n = 1;
    m_inited = 0; m_owner = 0; m_age = 0; m_grant = 0; m_err = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      e_bank = 2'b00;
      if (!m_inited) begin e_cmd = bus_if.init_cmd; e_addr = bus_if.init_addr; end
      else if (m_owner == 0) begin e_cmd = 4'b0111; e_addr = 12'd0; end
      else if (m_owner == 1) begin e_cmd = bus_if.aref_cmd; e_addr = bus_if.aref_addr; end
      else if (m_owner == 2) begin
        e_cmd = bus_if.wr_cmd; e_addr = bus_if.wr_addr; e_bank = bus_if.wr_bank;
      end else begin
        e_cmd = bus_if.rd_cmd; e_addr = bus_if.rd_addr; e_bank = bus_if.rd_bank;
      end
      e_en = {m_grant && m_owner == 1, m_grant && m_owner == 2, m_grant && m_owner == 3};
      n_checks++;
      if ({cmd, addr, bank} !== {e_cmd, e_addr, e_bank}) begin
        n_errors++; $display("FAIL rnd_pins[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, cmd, addr, bank,
                             e_cmd, e_addr, e_bank);
      end
      n_checks++;
      if ({bus_if.aref_en, bus_if.wr_en, bus_if.rd_en, arb_err} !== {e_en, m_err}) begin
        n_errors++; $display("FAIL rnd_pulses[%0d] got=%b exp=%b", cyc,
                             {bus_if.aref_en, bus_if.wr_en, bus_if.rd_en, arb_err}, {e_en, m_err});
      end
      if (m_inited && m_owner == 2 && bus_if.wr_dq_oe) begin
        #1;
        n_checks++;
        if (dq !== bus_if.wr_data) begin
          n_errors++; $display("FAIL rnd_dq[%0d] got=%h exp=%h", cyc, dq, bus_if.wr_data);
        end
      end else begin
        tb_dq = ~bus_if.wr_data; tb_dq_en = 1;
        #1;
        n_checks++;
        if (rd_data !== tb_dq) begin
          n_errors++; $display("FAIL rnd_dq_z[%0d] got=%h exp=%h", cyc, rd_data, tb_dq);
        end
        tb_dq_en = 0;
      end
      bus_if.init_done = ($urandom_range(0, 2) == 0) || m_inited;
      bus_if.aref_req  = ($urandom_range(0, 4) == 0);
      bus_if.wr_req    = ($urandom_range(0, 2) == 0);
      bus_if.rd_req    = ($urandom_range(0, 2) == 0);
      bus_if.aref_end  = ($urandom_range(0, 5) == 0);
      bus_if.wr_end    = ($urandom_range(0, 5) == 0);
      bus_if.rd_end    = ($urandom_range(0, 5) == 0);
      bus_if.wr_dq_oe  = $urandom_range(0, 1) == 1;
      bus_if.init_cmd  = 4'($urandom);  bus_if.init_addr = 12'($urandom);
      bus_if.aref_cmd  = 4'($urandom);  bus_if.aref_addr = 12'($urandom);
      bus_if.wr_cmd    = 4'($urandom);  bus_if.wr_addr   = 12'($urandom);
      bus_if.wr_bank   = 2'($urandom);  bus_if.wr_data   = 16'($urandom);
      bus_if.rd_cmd    = 4'($urandom);  bus_if.rd_addr   = 12'($urandom);
      bus_if.rd_bank   = 2'($urandom);
      model_step();
      @(negedge sclk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_dq();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
